// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the RV32 decode and execute stages:
// control-word layout, ALU opcodes and forwarding source encoding.
package rv_pipe_pkg;

    localparam int CTRL_W     = 9;
    localparam int CTRL_MEM_W = 5;

    localparam int CTRL_MEMTOREG_HI = 8;
    localparam int CTRL_MEMTOREG_LO = 7;
    localparam int CTRL_REGWRITE    = 6;
    localparam int CTRL_MEMREAD     = 5;
    localparam int CTRL_MEMWRITE    = 4;
    localparam int CTRL_ALUOP_HI    = 3;
    localparam int CTRL_ALUOP_LO    = 1;
    localparam int CTRL_ALUSRC      = 0;

    // Bit positions once the control word is trimmed to ctrl[8:4] for MEM.
    localparam int MEMCTRL_REGWRITE = CTRL_REGWRITE - CTRL_MEMWRITE;
    localparam int MEMCTRL_MEMREAD  = CTRL_MEMREAD - CTRL_MEMWRITE;

    localparam logic [CTRL_W-1:0] CTRL_ILLEGAL = 9'h1FF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    function automatic logic aluop_is_valid(input logic [2:0] aluop);
        return aluop[2:1] != 2'b11;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational integer ALU of the execute stage; op_valid_o flags the
// reserved opcodes, which produce a zero result.
module ex_alu
    import rv_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      aluop_i,
    output logic [XLEN-1:0] result_o,
    output logic            op_valid_o
);

    always_comb begin
        result_o   = '0;
        op_valid_o = aluop_is_valid(aluop_i);
        case (aluop_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLL: result_o = a_i << b_i[4:0];
            ALU_SLT: result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding from MEM/WB, ALU, load-use hazard
// detection and the EX->MEM pipeline register.
module ex_stage
    import rv_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CTRL_W-1:0]     ctrl_ex,
    input  logic [XLEN-1:0]       r_data1,
    input  logic [XLEN-1:0]       r_data2,
    input  logic [XLEN-1:0]       extended,
    input  logic [XLEN-1:0]       rd_ex,
    input  logic [REG_AW-1:0]     rs1_ex,
    input  logic [REG_AW-1:0]     rs2_ex,
    input  logic [XLEN-1:0]       pc4_ex,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  wb_write,
    input  logic [REG_AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    output logic [CTRL_MEM_W-1:0] ctrl_mem,
    output logic [XLEN-1:0]       alu_mem,
    output logic [XLEN-1:0]       store_mem,
    output logic [REG_AW-1:0]     rd_mem,
    output logic [XLEN-1:0]       pc4_mem,
    output logic                  hazard_o,
    output logic                  illegal_o
);

    logic [CTRL_MEM_W-1:0] ctrl_q, ctrl_d;
    logic [XLEN-1:0]       alu_q, alu_d;
    logic [XLEN-1:0]       store_q, store_d;
    logic [REG_AW-1:0]     rd_q, rd_d;
    logic [XLEN-1:0]       pc4_q, pc4_d;
    logic                  illegal_q, illegal_d;

    fwd_sel_e        fwd_a_sel, fwd_b_sel;
    logic [XLEN-1:0] fwd_a, fwd_b, op_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_op_valid;
    logic            mem_fwd_ok, wb_fwd_ok;
    logic            load_in_mem, rs2_needed;
    logic            ctrl_illegal;
    logic            hazard;
    logic            rd_unused;

    assign rd_unused = ^rd_ex[XLEN-1:REG_AW];

    // A load in MEM has no data yet, so only non-load writers forward from MEM.
    assign mem_fwd_ok = ctrl_q[MEMCTRL_REGWRITE] & ~ctrl_q[MEMCTRL_MEMREAD] & (rd_q != '0);
    assign wb_fwd_ok  = wb_write & (wb_addr != '0);

    always_comb begin
        fwd_a_sel = FWD_REG;
        if (mem_fwd_ok && (rd_q == rs1_ex)) begin
            fwd_a_sel = FWD_MEM;
        end else if (wb_fwd_ok && (wb_addr == rs1_ex)) begin
            fwd_a_sel = FWD_WB;
        end

        fwd_b_sel = FWD_REG;
        if (mem_fwd_ok && (rd_q == rs2_ex)) begin
            fwd_b_sel = FWD_MEM;
        end else if (wb_fwd_ok && (wb_addr == rs2_ex)) begin
            fwd_b_sel = FWD_WB;
        end
    end

    always_comb begin
        case (fwd_a_sel)
            FWD_MEM: fwd_a = alu_q;
            FWD_WB:  fwd_a = wb_data;
            default: fwd_a = r_data1;
        endcase

        case (fwd_b_sel)
            FWD_MEM: fwd_b = alu_q;
            FWD_WB:  fwd_b = wb_data;
            default: fwd_b = r_data2;
        endcase
    end

    assign op_b = ctrl_ex[CTRL_ALUSRC] ? extended : fwd_b;

    ex_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .a_i        (fwd_a),
        .b_i        (op_b),
        .aluop_i    (ctrl_ex[CTRL_ALUOP_HI:CTRL_ALUOP_LO]),
        .result_o   (alu_result),
        .op_valid_o (alu_op_valid)
    );

    assign ctrl_illegal = (ctrl_ex == CTRL_ILLEGAL) | ~alu_op_valid;

    // rs2 matters when it feeds operand B or is the data of a store.
    assign load_in_mem = ctrl_q[MEMCTRL_MEMREAD] & (rd_q != '0);
    assign rs2_needed  = ~ctrl_ex[CTRL_ALUSRC] | ctrl_ex[CTRL_MEMWRITE];
    assign hazard      = load_in_mem &
                         ((rd_q == rs1_ex) | ((rd_q == rs2_ex) & rs2_needed));

    always_comb begin
        ctrl_d    = ctrl_q;
        alu_d     = alu_q;
        store_d   = store_q;
        rd_d      = rd_q;
        pc4_d     = pc4_q;
        illegal_d = 1'b0;

        if (flush_i || (!stall_i && (hazard || ctrl_illegal))) begin
            ctrl_d    = '0;
            alu_d     = '0;
            store_d   = '0;
            rd_d      = '0;
            pc4_d     = '0;
            illegal_d = !flush_i && !hazard;
        end else if (!stall_i) begin
            ctrl_d  = ctrl_ex[CTRL_MEMTOREG_HI:CTRL_MEMWRITE];
            alu_d   = alu_result;
            store_d = fwd_b;
            rd_d    = rd_ex[REG_AW-1:0];
            pc4_d   = pc4_ex;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= '0;
            alu_q     <= '0;
            store_q   <= '0;
            rd_q      <= '0;
            pc4_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            alu_q     <= alu_d;
            store_q   <= store_d;
            rd_q      <= rd_d;
            pc4_q     <= pc4_d;
            illegal_q <= illegal_d;
        end
    end

    assign ctrl_mem  = ctrl_q;
    assign alu_mem   = alu_q;
    assign store_mem = store_q;
    assign rd_mem    = rd_q;
    assign pc4_mem   = pc4_q;
    assign hazard_o  = hazard;
    assign illegal_o = illegal_q;

endmodule
